utype_encoder: RTL and testbench
================================

# utype_encoder

U-type instruction encoder: the inverse of the `riscv_utype` field decoder. It accepts immediate, destination register and opcode fields over a valid/ready handshake and packs them into 32-bit RISC-V U-type words. Each word is buffered in a 2-entry queue and tagged with a sequential byte address. It sits between the instruction generator/assembler front end and the instruction-memory write port, and feeds round-trip checks against `riscv_utype`.

## Interface
- `ADDR_W`, 10: width of the emitted byte address.
- `BASE_ADDR`, 0: address assigned to the first instruction after reset; must be a multiple of 4.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input fields valid.
- `in_ready`  out  1  encoder can accept a field set this cycle.
- `in_imm`  in  20  upper immediate (inst[31:12]).
- `in_rd`  in  5  destination register (inst[11:7]).
- `in_opcode`  in  7  opcode (inst[6:0]).
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  consumer takes the head entry.
- `out_inst`  out  32  encoded instruction.
- `out_addr`  out  ADDR_W  byte address of `out_inst`.
- `err`  out  1  sticky illegal-opcode flag.
- `err_clr`  in  1  clears `err`.
- `count`  out  16  number of completed output handshakes, saturating.

## Operation
- Encoding: `inst = {in_imm, in_rd, in_opcode}`. This is purely positional; no sign handling.
- Input accept: `in_valid && in_ready`. Output transfer: `out_valid && out_ready`.
- 2-entry FIFO. Each entry stores {inst, addr}. Occupancy state machine:
  - EMPTY: on accept, go to ONE.
  - ONE: accept only, go to TWO. Transfer only, go to EMPTY. Accept and transfer together, stay in ONE.
  - TWO: transfer goes to ONE. No accept is possible in TWO.
- `in_ready = (state != TWO)`. It comes from registered state only; there is no combinational path from `out_ready`.
- `out_valid = (state != EMPTY)`. `out_inst` and `out_addr` always show the head entry. They hold stable while `out_valid && !out_ready`.
- Address counter `next_addr`:
  - Starts at `BASE_ADDR`.
  - Each enqueued entry takes `next_addr`, then `next_addr` advances by 4.
  - The counter wraps modulo 2^ADDR_W.
- `count` increments on every output transfer and saturates at 0xFFFF.
- `err`:
  - Set by a rejected opcode (see Configuration) and cleared by `err_clr`.
  - If an illegal accept and `err_clr` occur in the same cycle, set wins and `err` stays 1.

## Timing
- Reset values: state EMPTY, `out_valid`=0, `in_ready`=1 (first cycle after reset), `out_inst`=0, `out_addr`=`BASE_ADDR`, `err`=0, `count`=0, `next_addr`=`BASE_ADDR`.
- Latency: an input accepted in cycle N appears on `out_valid` in cycle N+1 if the FIFO was empty.
- Throughput: one instruction per cycle while `out_ready` stays high.
- Ordering is strict FIFO. There are no drops except illegal opcodes when checking is compiled in.
- Reset mid-operation flushes both entries and restores the address counter, `count` and `err` to their reset values. Any handshake in the reset cycle is ignored.

## Configuration
- Macro: `UTYPE_ENC_CHECK_EN`.
- Defined: only opcodes 7'b0110111 (LUI) and 7'b0010111 (AUIPC) are legal.
  - An illegal field set is still accepted, so the input handshake completes.
  - It is not enqueued, `next_addr` does not advance, and `err` sets on the following edge.
- Undefined: every opcode is encoded and enqueued. `err` and `err_clr` remain as ports, but `err` is tied to 0.

## Test plan
- Reset: assert `rst` for 2 cycles. Expect `out_valid`=0, `in_ready`=1, `err`=0, `count`=0, `out_addr`=0.
- Single LUI: accept imm=0x12345, rd=10, opcode=0x37 with `out_ready`=1. Expect `out_inst`=0x12345537 and `out_addr`=0 one cycle later; `count` becomes 1 after the transfer.
- Backpressure: hold `out_ready`=0 and offer three AUIPCs.
  - Expect `in_ready`=0 after two accepts.
  - Then raise `out_ready`: expect addresses 0, 4, 8 in order, with no loss or duplication.
- Illegal opcode: offer imm=0xABCDE, rd=1, opcode=0x13.
  - With `UTYPE_ENC_CHECK_EN`: nothing is emitted, `err`=1, and the next legal instruction gets the unadvanced address. Pulse `err_clr` and expect `err`=0.
  - Without the macro: expect `out_inst`=0xABCDE093.
- Wrap: with `ADDR_W`=4, emit 5 instructions. Expect addresses 0, 4, 8, 12, 0.
- Reset mid-stream: with the FIFO in TWO, assert `rst`. Expect `out_valid`=0 on the next cycle and the next emitted address equal to `BASE_ADDR`.

Source files
------------

// File: rtl/utype_enc_if.sv
// utype_enc_if: field-input / encoded-word-output handshake bundle for utype_encoder
interface utype_enc_if #(parameter int ADDR_W = 10);
  logic in_valid;
  logic in_ready;
  logic [19:0] in_imm;
  logic [4:0] in_rd;
  logic [6:0] in_opcode;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_inst;
  logic [ADDR_W-1:0] out_addr;
  modport master (
    output in_valid, in_imm, in_rd, in_opcode, out_ready,
    input  in_ready, out_valid, out_inst, out_addr
  );
  modport slave (
    input  in_valid, in_imm, in_rd, in_opcode, out_ready,
    output in_ready, out_valid, out_inst, out_addr
  );
endinterface

// File: rtl/utype_encoder.sv
// utype_encoder: packs U-type fields into 32-bit words, 2-entry FIFO with byte-address tags.
// Define UTYPE_ENC_CHECK_EN to drop non-LUI/AUIPC opcodes and flag them on err.
module utype_encoder #(
  parameter int ADDR_W = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic clk,
  input  logic rst,
  utype_enc_if.slave bus,
  output logic err,
  input  logic err_clr,
  output logic [15:0] count
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_n;
  logic [31:0] h_inst, t_inst;
  logic [ADDR_W-1:0] h_addr, t_addr, next_addr;
  logic acc, xfer, legal, enq, ld_new, ld_tail, ld_t;
  assign bus.in_ready = state != TWO;
  assign bus.out_valid = state != EMPTY;
  assign bus.out_inst = h_inst;
  assign bus.out_addr = h_addr;
  assign acc = bus.in_valid && bus.in_ready;
  assign xfer = bus.out_valid && bus.out_ready;
`ifdef UTYPE_ENC_CHECK_EN
  assign legal = bus.in_opcode == 7'b0110111 || bus.in_opcode == 7'b0010111;
  always_ff @(posedge clk)
    if (rst) err <= 1'b0;
    else err <= (acc && !legal) || (err && !err_clr);
`else
  assign legal = 1'b1;
  assign err = err_clr & 1'b0;
`endif
  assign enq = acc && legal;
  always_comb begin
    state_n = state;
    ld_new = 1'b0;
    ld_tail = 1'b0;
    ld_t = 1'b0;
    state_n = state == EMPTY ? (enq ? ONE : EMPTY) :
              state == ONE   ? (enq == xfer ? ONE : (enq ? TWO : EMPTY)) :
                               (xfer ? ONE : TWO);
    ld_new = enq && (state == EMPTY || (state == ONE && xfer));
    ld_t = enq && state == ONE && !xfer;
    ld_tail = state == TWO && xfer;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      h_inst <= '0;
      h_addr <= BASE_ADDR;
      t_inst <= '0;
      t_addr <= BASE_ADDR;
      next_addr <= BASE_ADDR;
      count <= '0;
    end else begin
      state <= state_n;
      if (ld_new) begin
        h_inst <= {bus.in_imm, bus.in_rd, bus.in_opcode};
        h_addr <= next_addr;
      end else if (ld_tail) begin
        h_inst <= t_inst;
        h_addr <= t_addr;
      end
      if (ld_t) begin
        t_inst <= {bus.in_imm, bus.in_rd, bus.in_opcode};
        t_addr <= next_addr;
      end
      if (enq) next_addr <= next_addr + ADDR_W'(4);
      if (xfer && count != 16'hFFFF) count <= count + 16'd1;
    end
  end
endmodule

// File: tb/tb_utype_encoder.sv
// tb_utype_encoder: directed checks of utype_encoder (ADDR_W=10 main instance, ADDR_W=4 wrap instance)
module tb_utype_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_a, err_b, clr_a, clr_b;
  logic [15:0] count_a, count_b;
  int checks = 0;
  int failures = 0;
  utype_enc_if #(.ADDR_W(10)) a();
  utype_enc_if #(.ADDR_W(4)) w();
  utype_encoder #(.ADDR_W(10)) u_a (.clk(clk), .rst(rst), .bus(a), .err(err_a), .err_clr(clr_a), .count(count_a));
  utype_encoder #(.ADDR_W(4)) u_b (.clk(clk), .rst(rst), .bus(w), .err(err_b), .err_clr(clr_b), .count(count_b));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic offer(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    a.in_valid = 1'b1;
    a.in_imm = imm;
    a.in_rd = rd;
    a.in_opcode = op;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  initial begin
    a.in_valid = 0; a.in_imm = 0; a.in_rd = 0; a.in_opcode = 0; a.out_ready = 0;
    w.in_valid = 0; w.in_imm = 0; w.in_rd = 0; w.in_opcode = 7'h37; w.out_ready = 0;
    clr_a = 0; clr_b = 0;
    #1;
    do_reset();
    chk("rst_out_valid", 32'(a.out_valid), 0);
    chk("rst_in_ready", 32'(a.in_ready), 1);
    chk("rst_err", 32'(err_a), 0);
    chk("rst_count", 32'(count_a), 0);
    chk("rst_out_addr", 32'(a.out_addr), 0);
    chk("rst_out_inst", a.out_inst, 0);
    // single LUI
    a.out_ready = 1;
    offer(20'h12345, 5'd10, 7'h37);
    tick();
    a.in_valid = 0;
    chk("lui_valid", 32'(a.out_valid), 1);
    chk("lui_inst", a.out_inst, 32'h12345537);
    chk("lui_addr", 32'(a.out_addr), 0);
    tick();
    chk("lui_count", 32'(count_a), 1);
    chk("lui_drained", 32'(a.out_valid), 0);
    // backpressure with three AUIPCs
    do_reset();
    a.out_ready = 0;
    offer(20'h00001, 5'd1, 7'h17);
    tick();
    chk("bp_ready1", 32'(a.in_ready), 1);
    offer(20'h00002, 5'd1, 7'h17);
    tick();
    chk("bp_ready2", 32'(a.in_ready), 0);
    offer(20'h00003, 5'd1, 7'h17);
    tick();
    chk("bp_full_ready", 32'(a.in_ready), 0);
    chk("bp_hold_inst", a.out_inst, 32'h00001097);
    chk("bp_hold_addr", 32'(a.out_addr), 0);
    a.out_ready = 1;
    tick();
    chk("bp_2nd_inst", a.out_inst, 32'h00002097);
    chk("bp_2nd_addr", 32'(a.out_addr), 4);
    chk("bp_2nd_ready", 32'(a.in_ready), 1);
    tick();
    a.in_valid = 0;
    chk("bp_3rd_inst", a.out_inst, 32'h00003097);
    chk("bp_3rd_addr", 32'(a.out_addr), 8);
    tick();
    chk("bp_empty", 32'(a.out_valid), 0);
    chk("bp_count", 32'(count_a), 3);
    // illegal opcode
    offer(20'hABCDE, 5'd1, 7'h13);
    tick();
    a.in_valid = 0;
`ifdef UTYPE_ENC_CHECK_EN
    chk("ill_dropped", 32'(a.out_valid), 0);
    chk("ill_err", 32'(err_a), 1);
    offer(20'h00005, 5'd2, 7'h37);
    tick();
    chk("ill_next_addr", 32'(a.out_addr), 12);
    chk("ill_next_inst", a.out_inst, 32'h00005137);
    chk("ill_err_sticky", 32'(err_a), 1);
    offer(20'hABCDE, 5'd1, 7'h13);
    clr_a = 1;
    tick();
    a.in_valid = 0;
    chk("ill_set_wins", 32'(err_a), 1);
    tick();
    clr_a = 0;
    chk("ill_err_clr", 32'(err_a), 0);
`else
    chk("ill_valid", 32'(a.out_valid), 1);
    chk("ill_inst", a.out_inst, 32'hABCDE093);
    chk("ill_addr", 32'(a.out_addr), 12);
    chk("ill_err_tied", 32'(err_a), 0);
    tick();
`endif
    chk("ill_empty", 32'(a.out_valid), 0);
    // reset with FIFO full, handshake held through the reset cycle
    a.out_ready = 0;
    offer(20'h00007, 5'd3, 7'h37);
    tick();
    tick();
    chk("mid_full", 32'(a.in_ready), 0);
    rst = 1;
    tick();
    rst = 0;
    a.in_valid = 0;
    chk("mid_valid", 32'(a.out_valid), 0);
    chk("mid_ready", 32'(a.in_ready), 1);
    chk("mid_count", 32'(count_a), 0);
    offer(20'h00008, 5'd4, 7'h17);
    tick();
    a.in_valid = 0;
    chk("mid_addr", 32'(a.out_addr), 0);
    chk("mid_inst", a.out_inst, 32'h00008217);
    // address wrap with ADDR_W=4
    w.out_ready = 1;
    w.in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      w.in_imm = 20'(i);
      tick();
      chk($sformatf("wrap_addr%0d", i), 32'(w.out_addr), 32'((i * 4) % 16));
    end
    w.in_valid = 0;
    tick();
    chk("wrap_count", 32'(count_b), 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
